serial_fifo_bridge: RTL

Memory-mapped byte-serial peripheral for the CPU bus; successor to the single-register AVR serial port. Sits between the CPU bus (`addr`/`din`/`dout`/`wr`/`rd`) and the byte-stream side of `avr_interface`. Adds parametrised TX and RX FIFOs, a TX drain state machine, sticky overflow flags, occupancy readback, and a level-sensitive interrupt.

---
 rtl/serial_fifo_bridge_if.sv | 20 ++
 rtl/serial_fifo_bridge.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_fifo_bridge_if.sv
// ---------------------------------------------------------------------------
// serial_fifo_bridge_if
// CPU-side register bus of the serial FIFO bridge.
//   addr : 16-bit CPU address
//   din  : 8-bit write data
//   dout : 8-bit read data (combinational, driven by the peripheral)
//   wr   : write strobe, one write per clk where high
//   rd   : read strobe, may be held several cycles per access
// Modports: master (CPU side), slave (peripheral side).
// ---------------------------------------------------------------------------
interface serial_fifo_bridge_if;
  logic [15:0] addr;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        wr;
  logic        rd;

  modport master (output addr, output din, output wr, output rd, input dout);
  modport slave  (input addr, input din, input wr, input rd, output dout);
endinterface

// File: rtl/serial_fifo_bridge.sv
// ---------------------------------------------------------------------------
// serial_fifo_bridge
// Memory-mapped byte-serial peripheral between the CPU bus and the byte-stream
// side of avr_interface. TX and RX FIFOs, a TX drain FSM, sticky overflow
// flags, occupancy readback and a level interrupt.
//
// Register map (offsets from BASE_ADDR):
//   +0 STAT  (ro) {irq, rx_ovf, tx_ovf, rx_full, avr_ready, rx_nonempty,
//                  tx_full, tx_active}
//   +1 CTL   (rw) [0] tx_flush, [1] rx_flush, [4] clr_ovf (strobes, read 0)
//                 [2] rx_irq_en, [3] tx_irq_en, [5] loopback
//   +2 TXDAT (wo) push byte into TX FIFO
//   +3 RXDAT (ro) RX FIFO head, popped on the rising edge of rd
//   +4 TXCNT (ro) TX occupancy
//   +5 RXCNT (ro) RX occupancy
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   bus          : CPU register bus (serial_fifo_bridge_if.slave)
//   irq          : level interrupt
//   tx_data      : byte to avr_interface, new_tx_data : one-cycle send pulse
//   tx_busy      : serializer busy, tx_block : AVR RX buffer full
//   rx_data      : received byte, new_rx_data : one-cycle receive pulse
//   avr_ready    : AVR link up
//
// Build option: define SERIAL_FIFO_LOOPBACK_EN to implement CTL[5] loopback,
// which routes TX bytes into the RX FIFO instead of the link.
// ---------------------------------------------------------------------------
module serial_fifo_bridge #(
  parameter logic [15:0] BASE_ADDR = 16'hfea0,
  parameter int          TX_DEPTH  = 16,
  parameter int          RX_DEPTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_fifo_bridge_if.slave   bus,
  output logic                  irq,
  output logic [7:0]            tx_data,
  output logic                  new_tx_data,
  input  logic                  tx_busy,
  input  logic                  tx_block,
  input  logic [7:0]            rx_data,
  input  logic                  new_rx_data,
  input  logic                  avr_ready
);

  localparam int TXA = $clog2(TX_DEPTH);
  localparam int RXA = $clog2(RX_DEPTH);
  localparam logic [TXA:0] TX_FULL_CNT = (TXA+1)'(TX_DEPTH);
  localparam logic [RXA:0] RX_FULL_CNT = (RXA+1)'(RX_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT} tx_state_t;

  tx_state_t state, state_nx;
  logic      tx_start;

  // address decode and control strobes
  logic sel_stat, sel_ctl, sel_txdat, sel_rxdat, sel_txcnt, sel_rxcnt;
  assign sel_stat  = (bus.addr == BASE_ADDR);
  assign sel_ctl   = (bus.addr == BASE_ADDR + 16'd1);
  assign sel_txdat = (bus.addr == BASE_ADDR + 16'd2);
  assign sel_rxdat = (bus.addr == BASE_ADDR + 16'd3);
  assign sel_txcnt = (bus.addr == BASE_ADDR + 16'd4);
  assign sel_rxcnt = (bus.addr == BASE_ADDR + 16'd5);

  logic ctl_wr, tx_flush, rx_flush, clr_ovf;
  assign ctl_wr   = bus.wr & sel_ctl;
  assign tx_flush = ctl_wr & bus.din[0];
  assign rx_flush = ctl_wr & bus.din[1];
  assign clr_ovf  = ctl_wr & bus.din[4];

  logic rx_irq_en, tx_irq_en, rd_q, tx_ovf, rx_ovf, loopback, lb_inflight;

`ifdef SERIAL_FIFO_LOOPBACK_EN
  always_ff @(posedge clk) begin
    if (rst)         loopback <= 1'b0;
    else if (ctl_wr) loopback <= bus.din[5];
  end
`else
  assign loopback = 1'b0;
`endif

  // TX FIFO
  logic [7:0]     tx_mem [TX_DEPTH];
  logic [TXA-1:0] tx_wp, tx_rp;
  logic [TXA:0]   tx_cnt;
  logic           tx_ne, tx_full, tx_push_req, tx_do_push, tx_do_pop, tx_ovf_set;

  assign tx_ne       = (tx_cnt != '0);
  assign tx_full     = (tx_cnt == TX_FULL_CNT);
  assign tx_push_req = bus.wr & sel_txdat;
  // The byte was captured on entry to LOAD; this pop just retires it.
  assign tx_do_pop   = (state == S_LOAD) & tx_ne & ~tx_flush;
  assign tx_do_push  = tx_push_req & (~tx_full | tx_do_pop) & ~tx_flush;
  assign tx_ovf_set  = tx_push_req & tx_full & ~tx_do_pop;

  always_ff @(posedge clk) begin
    if (tx_do_push) tx_mem[tx_wp] <= bus.din;
  end

  always_ff @(posedge clk) begin
    if (rst || tx_flush) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_do_push) tx_wp <= tx_wp + 1'b1;
      if (tx_do_pop)  tx_rp <= tx_rp + 1'b1;
      case ({tx_do_push, tx_do_pop})
        2'b10:   tx_cnt <= tx_cnt + 1'b1;
        2'b01:   tx_cnt <= tx_cnt - 1'b1;
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  // RX FIFO
  logic [7:0]     rx_mem [RX_DEPTH];
  logic [RXA-1:0] rx_wp, rx_rp;
  logic [RXA:0]   rx_cnt;
  logic           rx_ne, rx_full, rx_push_req, rx_pop_req, rx_do_push, rx_do_pop;
  logic           rx_ovf_set, lb_push;
  logic [7:0]     rx_push_data;

  assign rx_ne        = (rx_cnt != '0);
  assign rx_full      = (rx_cnt == RX_FULL_CNT);
  assign lb_push      = (state == S_LOAD) & lb_inflight;
  assign rx_push_req  = lb_push | (new_rx_data & ~loopback);
  assign rx_push_data = lb_push ? tx_data : rx_data;
  // Only the first clk of a (possibly stretched) read pops.
  assign rx_pop_req   = bus.rd & ~rd_q & sel_rxdat;
  assign rx_do_pop    = rx_pop_req & rx_ne & ~rx_flush;
  assign rx_do_push   = rx_push_req & (~rx_full | rx_do_pop) & ~rx_flush;
  assign rx_ovf_set   = rx_push_req & rx_full & ~rx_do_pop;

  always_ff @(posedge clk) begin
    if (rx_do_push) rx_mem[rx_wp] <= rx_push_data;
  end

  always_ff @(posedge clk) begin
    if (rst || rx_flush) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_do_push) rx_wp <= rx_wp + 1'b1;
      if (rx_do_pop)  rx_rp <= rx_rp + 1'b1;
      case ({rx_do_push, rx_do_pop})
        2'b10:   rx_cnt <= rx_cnt + 1'b1;
        2'b01:   rx_cnt <= rx_cnt - 1'b1;
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  // control registers and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_irq_en <= 1'b0;
      tx_irq_en <= 1'b0;
      rd_q      <= 1'b0;
      tx_ovf    <= 1'b0;
      rx_ovf    <= 1'b0;
    end else begin
      rd_q <= bus.rd;
      if (ctl_wr) {tx_irq_en, rx_irq_en} <= bus.din[3:2];
      // a new overflow in the clearing cycle keeps the flag set
      tx_ovf <= tx_ovf_set | (tx_ovf & ~clr_ovf);
      rx_ovf <= rx_ovf_set | (rx_ovf & ~clr_ovf);
    end
  end

  // TX drain FSM
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    tx_start = 1'b0;
    case (state)
      S_IDLE: begin
        if (tx_ne && (loopback || (!tx_busy && !tx_block))) begin
          state_nx = S_LOAD;
          tx_start = 1'b1;
        end
      end
      S_LOAD:  state_nx = S_WAIT;
      S_WAIT:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs registered on LOAD entry so the byte survives a flush in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      new_tx_data <= 1'b0;
      lb_inflight <= 1'b0;
      tx_data     <= 8'h00;
    end else begin
      new_tx_data <= tx_start & ~loopback;
      lb_inflight <= tx_start & loopback;
      if (tx_start) tx_data <= tx_mem[tx_rp];
    end
  end

  // readback
  logic       tx_active;
  logic [7:0] stat, ctl_rb, dout_c;

  assign tx_active = tx_ne | (state != S_IDLE) | tx_busy;
  assign irq       = (rx_irq_en & rx_ne) | (tx_irq_en & ~tx_ne & (state == S_IDLE));
  assign stat      = {irq, rx_ovf, tx_ovf, rx_full, avr_ready, rx_ne, tx_full, tx_active};
  assign ctl_rb    = {2'b00, loopback, 1'b0, tx_irq_en, rx_irq_en, 2'b00};

  always_comb begin
    dout_c = 8'h00;
    if (bus.rd) begin
      if (sel_stat)       dout_c = stat;
      else if (sel_ctl)   dout_c = ctl_rb;
      else if (sel_rxdat) dout_c = rx_ne ? rx_mem[rx_rp] : 8'h00;
      else if (sel_txcnt) dout_c = 8'(tx_cnt);
      else if (sel_rxcnt) dout_c = 8'(rx_cnt);
      else                dout_c = 8'h00;
    end
  end

  assign bus.dout = dout_c;

endmodule
